// File: rtl/csr_pkg.sv
// Shared CSR address map, operation encodings and fixed read-only values.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_FFLAGS   = 12'h001;
  localparam logic [11:0] CSR_FRM      = 12'h002;
  localparam logic [11:0] CSR_FCSR     = 12'h003;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH= 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [31:0] MISA_VALUE   = 32'h4000_1120;
  localparam logic [1:0]  MSTATUS_MPP  = 2'b11;
  // mtvec and mepc are word aligned; the two low bits always read 0.
  localparam logic [31:0] ALIGN4_MASK  = 32'hFFFF_FFFC;

  // Read-modify-write combine for the CSR instruction family.
  function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] operand);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = operand;
      CSR_OP_RS: res = old_val | operand;
      CSR_OP_RC: res = old_val & ~operand;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter whose 32-bit halves can be overwritten
// independently; the half not being written keeps counting with carry.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] count
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;
  logic [63:0] cnt_inc;

  // Increment first, then let a software write replace its half.
  always_comb begin
    cnt_inc = cnt_q + {63'h0, inc_en};
    cnt_d   = cnt_inc;
    if (wr_lo) cnt_d[31:0]  = wr_data;
    if (wr_hi) cnt_d[63:32] = wr_data;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 64'h0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: FP status, trap CSRs, cycle/instret counters.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        imm_sel,
  input  logic        rs1_zero,
  output logic [31:0] rd_data,
  output logic        illegal,
  input  logic        instr_retired,
  input  logic [4:0]  fflags_set,
  input  logic        trap_en,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret,
  output logic [2:0]  frm,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mstatus_mie
);

  csr_op_e     op_e;
  logic [31:0] operand;
  logic [31:0] rd_val;
  logic [31:0] wdata;
  logic        addr_impl;
  logic        addr_ro;
  logic        wr_intent;
  logic        sw_wr;

  logic [4:0]  fflags_q,   fflags_d;
  logic [2:0]  frm_q,      frm_d;
  logic        mie_bit_q,  mie_bit_d;
  logic        mpie_q,     mpie_d;
  logic [31:0] mie_q,      mie_d;
  logic [31:0] mtvec_q,    mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q,     mepc_d;
  logic [31:0] mcause_q,   mcause_d;
  logic [31:0] mtval_q,    mtval_d;

  logic [31:0] mstatus_rd;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  assign op_e       = csr_op_e'(csr_op);
  assign operand    = imm_sel ? {27'h0, zimm} : rs1_data;
  assign mstatus_rd = {19'h0, MSTATUS_MPP, 3'h0, mpie_q, 3'h0, mie_bit_q, 3'h0};

  // RS/RC with a zero source are pure reads and must not count as writes.
  assign wr_intent = (op_e == CSR_OP_RW) ||
                     (((op_e == CSR_OP_RS) || (op_e == CSR_OP_RC)) && !rs1_zero);
  assign addr_ro   = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MISA);
  assign illegal   = csr_en && (!addr_impl || (addr_ro && wr_intent));
  // A trap in the same cycle cancels the software write entirely.
  assign sw_wr     = csr_en && addr_impl && !addr_ro && wr_intent && !trap_en;
  assign wdata     = csr_apply_op(op_e, rd_val, operand);

  // Read decode: pre-write value of the addressed CSR, 0 when unimplemented.
  always_comb begin
    rd_val    = 32'h0;
    addr_impl = 1'b1;
    case (csr_addr)
      CSR_FFLAGS:    rd_val = {27'h0, fflags_q};
      CSR_FRM:       rd_val = {29'h0, frm_q};
      CSR_FCSR:      rd_val = {24'h0, frm_q, fflags_q};
      CSR_MSTATUS:   rd_val = mstatus_rd;
      CSR_MISA:      rd_val = MISA_VALUE;
      CSR_MIE:       rd_val = mie_q;
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_q;
      CSR_MCAUSE:    rd_val = mcause_q;
      CSR_MTVAL:     rd_val = mtval_q;
      CSR_MCYCLE:    rd_val = mcycle[31:0];
      CSR_MCYCLEH:   rd_val = mcycle[63:32];
      CSR_MINSTRET:  rd_val = minstret[31:0];
      CSR_MINSTRETH: rd_val = minstret[63:32];
      CSR_CYCLE:     rd_val = mcycle[31:0];
      CSR_CYCLEH:    rd_val = mcycle[63:32];
      CSR_INSTRET:   rd_val = minstret[31:0];
      CSR_INSTRETH:  rd_val = minstret[63:32];
      CSR_MHARTID:   rd_val = HART_ID;
      default:       addr_impl = 1'b0;
    endcase
  end

  assign rd_data = rd_val;

  // Next-state: hardware flag accumulation, software writes, then trap/mret.
  always_comb begin
    fflags_d   = fflags_q | fflags_set;
    frm_d      = frm_q;
    mie_bit_d  = mie_bit_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;

    if (sw_wr) begin
      case (csr_addr)
        CSR_FFLAGS:   fflags_d = wdata[4:0];
        CSR_FRM:      frm_d    = wdata[2:0];
        CSR_FCSR: begin
          frm_d    = wdata[7:5];
          fflags_d = wdata[4:0];
        end
        CSR_MSTATUS: begin
          mie_bit_d = wdata[3];
          mpie_d    = wdata[7];
        end
        CSR_MIE:      mie_d      = wdata;
        CSR_MTVEC:    mtvec_d    = wdata & ALIGN4_MASK;
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = wdata & ALIGN4_MASK;
        CSR_MCAUSE:   mcause_d   = wdata;
        CSR_MTVAL:    mtval_d    = wdata;
        default:      ;
      endcase
    end

    if (trap_en) begin
      mepc_d    = trap_pc & ALIGN4_MASK;
      mcause_d  = trap_cause;
      mtval_d   = trap_val;
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
    end else if (mret) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
    end
  end

  // CSR state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_q   <= 5'h0;
      frm_q      <= 3'h0;
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= 32'h0;
      mtvec_q    <= 32'h0;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
    end else begin
      fflags_q   <= fflags_d;
      frm_q      <= frm_d;
      mie_bit_q  <= mie_bit_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_en  (1'b1),
    .wr_lo   (sw_wr && (csr_addr == CSR_MCYCLE)),
    .wr_hi   (sw_wr && (csr_addr == CSR_MCYCLEH)),
    .wr_data (wdata),
    .count   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_en  (instr_retired),
    .wr_lo   (sw_wr && (csr_addr == CSR_MINSTRET)),
    .wr_hi   (sw_wr && (csr_addr == CSR_MINSTRETH)),
    .wr_data (wdata),
    .count   (minstret)
  );

  assign frm         = frm_q;
  assign mtvec_out   = mtvec_q;
  assign mepc_out    = mepc_q;
  assign mstatus_mie = mie_bit_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file with a queue of expected values.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_en = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] rs1_data = 32'h0;
  logic [4:0]  zimm = 5'h0;
  logic        imm_sel = 1'b0;
  logic        rs1_zero = 1'b0;
  logic [31:0] rd_data;
  logic        illegal;
  logic        instr_retired = 1'b0;
  logic [4:0]  fflags_set = 5'h0;
  logic        trap_en = 1'b0;
  logic [31:0] trap_cause = 32'h0;
  logic [31:0] trap_pc = 32'h0;
  logic [31:0] trap_val = 32'h0;
  logic        mret = 1'b0;
  logic [2:0]  frm;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        mstatus_mie;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  int checks   = 0;
  int failures = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  csr_file #(.HART_ID(32'd3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_en        (csr_en),
    .csr_op        (csr_op),
    .csr_addr      (csr_addr),
    .rs1_data      (rs1_data),
    .zimm          (zimm),
    .imm_sel       (imm_sel),
    .rs1_zero      (rs1_zero),
    .rd_data       (rd_data),
    .illegal       (illegal),
    .instr_retired (instr_retired),
    .fflags_set    (fflags_set),
    .trap_en       (trap_en),
    .trap_cause    (trap_cause),
    .trap_pc       (trap_pc),
    .trap_val      (trap_val),
    .mret          (mret),
    .frm           (frm),
    .mtvec_out     (mtvec_out),
    .mepc_out      (mepc_out),
    .mstatus_mie   (mstatus_mie)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=0x%08h expected=entry", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", t, obs, e);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the next one.
  task automatic csr_issue(input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] data, input logic isel,
                           input logic [4:0] z, input logic rz,
                           input logic chk_rd, input logic [31:0] exp_rd,
                           input logic exp_ill, input string tag);
    csr_en   = 1'b1;
    csr_op   = op;
    csr_addr = addr;
    rs1_data = data;
    imm_sel  = isel;
    zimm     = z;
    rs1_zero = rz;
    #1;
    if (chk_rd) begin
      expect_val({tag, "_rd"}, exp_rd);
      check(rd_data);
    end
    expect_val({tag, "_illegal"}, {31'h0, exp_ill});
    check({31'h0, illegal});
    @(posedge clk); #1;
    csr_en   = 1'b0;
    csr_op   = OP_NONE;
    rs1_data = 32'h0;
    imm_sel  = 1'b0;
    zimm     = 5'h0;
    rs1_zero = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    csr_issue(OP_RS, addr, 32'h0, 1'b0, 5'h0, 1'b1, 1'b1, exp, 1'b0, tag);
  endtask

  initial begin
    // Reset values, observed while reset is held.
    #3;
    expect_val("rst_rd_unimpl", 32'h0);      check(rd_data);
    expect_val("rst_illegal", 32'h0);        check({31'h0, illegal});
    expect_val("rst_frm", 32'h0);            check({29'h0, frm});
    expect_val("rst_mtvec_out", 32'h0);      check(mtvec_out);
    expect_val("rst_mepc_out", 32'h0);       check(mepc_out);
    expect_val("rst_mstatus_mie", 32'h0);    check({31'h0, mstatus_mie});
    csr_addr = 12'h300; #1;
    expect_val("rst_mstatus", 32'h0000_1800); check(rd_data);
    csr_addr = 12'h301; #1;
    expect_val("misa", 32'h4000_1120);        check(rd_data);
    csr_addr = 12'hF14; #1;
    expect_val("mhartid", 32'd3);             check(rd_data);
    csr_addr = 12'h000;

    // Release between edges; 10 idle edges give mcycle = 10.
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    csr_read(12'hB00, 32'd10, "mcycle_10");
    csr_issue(OP_RW, 12'hB00, 32'hFFFF_FFFF, 1'b0, 5'h0, 1'b0, 1'b1, 32'd11, 1'b0, "mcycle_wr");
    csr_read(12'hB00, 32'hFFFF_FFFF, "mcycle_lo_written");
    csr_read(12'hB80, 32'd1, "mcycleh_carry");
    csr_read(12'hC80, 32'd1, "cycleh_shadow");

    // minstret counting and 64-bit wrap.
    csr_read(12'hB02, 32'd0, "minstret_0");
    instr_retired = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    instr_retired = 1'b0;
    csr_read(12'hC02, 32'd3, "instret_3");
    csr_issue(OP_RW, 12'hB82, 32'hFFFF_FFFF, 1'b0, 5'h0, 1'b0, 1'b1, 32'd0, 1'b0, "minstreth_wr");
    csr_issue(OP_RW, 12'hB02, 32'hFFFF_FFFF, 1'b0, 5'h0, 1'b0, 1'b1, 32'd3, 1'b0, "minstret_wr");
    csr_read(12'hB82, 32'hFFFF_FFFF, "minstreth_max");
    instr_retired = 1'b1;
    @(posedge clk); #1;
    instr_retired = 1'b0;
    csr_read(12'hB02, 32'd0, "minstret_wrap_lo");
    csr_read(12'hB82, 32'd0, "minstret_wrap_hi");

    // mscratch read-modify-write family.
    csr_issue(OP_RW, 12'h340, 32'hDEAD_BEEF, 1'b0, 5'h0, 1'b0, 1'b1, 32'h0, 1'b0, "mscratch_rw");
    csr_read(12'h340, 32'hDEAD_BEEF, "mscratch_rd1");
    csr_issue(OP_RS, 12'h340, 32'h0000_00F0, 1'b0, 5'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, "mscratch_rs");
    csr_read(12'h340, 32'hDEAD_BEFF, "mscratch_rd2");
    csr_issue(OP_RC, 12'h340, 32'hDE00_0000, 1'b0, 5'h0, 1'b0, 1'b1, 32'hDEAD_BEFF, 1'b0, "mscratch_rc");
    csr_read(12'h340, 32'h00AD_BEFF, "mscratch_rd3");
    csr_issue(OP_RC, 12'h340, 32'hFFFF_FFFF, 1'b0, 5'h0, 1'b1, 1'b1, 32'h00AD_BEFF, 1'b0, "mscratch_rc_rz");
    csr_read(12'h340, 32'h00AD_BEFF, "mscratch_no_side_effect");
    csr_issue(OP_RW, 12'h340, 32'hFFFF_FFFF, 1'b1, 5'h15, 1'b0, 1'b1, 32'h00AD_BEFF, 1'b0, "mscratch_rwi");
    csr_read(12'h340, 32'h0000_0015, "mscratch_zimm");

    // mtvec alignment.
    csr_issue(OP_RW, 12'h305, 32'h1234_5677, 1'b0, 5'h0, 1'b0, 1'b1, 32'h0, 1'b0, "mtvec_rw");
    expect_val("mtvec_out", 32'h1234_5674); check(mtvec_out);
    csr_read(12'h305, 32'h1234_5674, "mtvec_rd");

    // Floating-point flags and rounding mode.
    fflags_set = 5'b00001;
    @(posedge clk); #1;
    fflags_set = 5'b10000;
    @(posedge clk); #1;
    fflags_set = 5'b00000;
    csr_read(12'h003, 32'h11, "fcsr_accum");
    csr_issue(OP_RW, 12'h002, 32'h0, 1'b1, 5'h5, 1'b0, 1'b1, 32'h0, 1'b0, "frm_wri");
    expect_val("frm_out", 32'h5); check({29'h0, frm});
    csr_read(12'h003, 32'hB1, "fcsr_frm_flags");
    csr_issue(OP_RW, 12'h003, 32'h0, 1'b1, 5'h0, 1'b1, 1'b1, 32'hB1, 1'b0, "fcsr_wri0");
    csr_read(12'h003, 32'h0, "fcsr_cleared");
    fflags_set = 5'b00100;
    csr_issue(OP_RW, 12'h001, 32'h0, 1'b1, 5'h2, 1'b0, 1'b1, 32'h0, 1'b0, "fflags_wr_vs_set");
    fflags_set = 5'b00000;
    csr_read(12'h001, 32'h2, "fflags_sw_wins");

    // Interrupt enable, trap entry (beats a write and mret), then mret.
    csr_issue(OP_RS, 12'h300, 32'h0, 1'b1, 5'h8, 1'b0, 1'b1, 32'h0000_1800, 1'b0, "mstatus_rsi");
    expect_val("mie_set", 32'h1); check({31'h0, mstatus_mie});
    csr_read(12'h300, 32'h0000_1808, "mstatus_mie1");
    trap_en    = 1'b1;
    mret       = 1'b1;
    trap_pc    = 32'h100;
    trap_cause = 32'd2;
    trap_val   = 32'h0000_0BAD;
    csr_issue(OP_RW, 12'h341, 32'h0000_5554, 1'b0, 5'h0, 1'b0, 1'b1, 32'h0, 1'b0, "trap_vs_mepc_wr");
    trap_en = 1'b0;
    mret    = 1'b0;
    expect_val("trap_mepc_out", 32'h100); check(mepc_out);
    expect_val("trap_mie_off", 32'h0);    check({31'h0, mstatus_mie});
    csr_read(12'h342, 32'd2, "trap_mcause");
    csr_read(12'h343, 32'h0000_0BAD, "trap_mtval");
    csr_read(12'h300, 32'h0000_1880, "trap_mstatus_mpie");
    mret = 1'b1;
    @(posedge clk); #1;
    mret = 1'b0;
    expect_val("mret_mie_on", 32'h1); check({31'h0, mstatus_mie});
    csr_read(12'h300, 32'h0000_1888, "mret_mstatus");

    // Illegal accesses leave state untouched.
    csr_issue(OP_RW, 12'hC00, 32'h1234, 1'b0, 5'h0, 1'b0, 1'b0, 32'h0, 1'b1, "ro_cycle_wr");
    csr_issue(OP_RW, 12'h7FF, 32'h1234, 1'b0, 5'h0, 1'b0, 1'b1, 32'h0, 1'b1, "unimpl_wr");
    csr_issue(OP_RS, 12'hC00, 32'h0, 1'b0, 5'h0, 1'b1, 1'b0, 32'h0, 1'b0, "ro_cycle_rs_rz");
    csr_issue(OP_RW, 12'hC02, 32'h5, 1'b0, 5'h0, 1'b0, 1'b1, 32'h0, 1'b1, "ro_instret_wr");
    csr_read(12'hB02, 32'h0, "instret_unchanged");
    csr_issue(OP_RW, 12'h301, 32'h0, 1'b0, 5'h0, 1'b0, 1'b1, 32'h4000_1120, 1'b1, "misa_wr");
    csr_issue(OP_NONE, 12'h7FF, 32'h0, 1'b0, 5'h0, 1'b0, 1'b1, 32'h0, 1'b1, "unimpl_read");

    // Reset in the middle of a pending write discards it.
    csr_en   = 1'b1;
    csr_op   = OP_RW;
    csr_addr = 12'h340;
    rs1_data = 32'h0000_1234;
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    csr_en   = 1'b0;
    csr_op   = OP_NONE;
    rs1_data = 32'h0;
    rst_n    = 1'b1;
    expect_val("rst2_mtvec_out", 32'h0); check(mtvec_out);
    expect_val("rst2_frm", 32'h0);       check({29'h0, frm});
    csr_read(12'h340, 32'h0, "rst2_mscratch");
    csr_read(12'h300, 32'h0000_1800, "rst2_mstatus");

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter HART_ID, default 0, value returned by mhartid.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports csr_en input 1 (CSR instruction valid) and csr_op input 2 (01 RW, 10 RS, 11 RC, 00 none).
REQ-005 SHALL have ports csr_addr input 12, rs1_data input 32, zimm input 5, and imm_sel input 1 (1 selects zero-extended zimm as the operand).
REQ-006 SHALL have port rs1_zero input 1; it is 1 when the rs1 field or zimm is 0.
REQ-007 SHALL have ports rd_data output 32 (old CSR value) and illegal output 1.
REQ-008 SHALL have ports instr_retired input 1 and fflags_set input 5 (FPU exception flags, OR-accumulated).
REQ-009 SHALL have ports trap_en input 1, trap_cause input 32, trap_pc input 32, trap_val input 32, and mret input 1.
REQ-010 SHALL have outputs frm 3, mtvec_out 32, mepc_out 32, and mstatus_mie 1.

Function
REQ-011 SHALL implement the following CSRs:
  - fflags 0x001 (5b), frm 0x002 (3b), fcsr 0x003 ({frm,fflags}, 8b)
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] reads 11
  - misa 0x301: read-only 0x40001120
  - mie 0x304, mtvec 0x305 (bits[1:0] read 0), mscratch 0x340, mepc 0x341 (bits[1:0] read 0), mcause 0x342, mtval 0x343
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82
  - read-only shadows cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82
  - mhartid 0xF14
REQ-012 SHALL drive rd_data combinationally with the pre-write value of the addressed CSR; unimplemented bits read 0.
REQ-013 SHALL compute the new value as RW: op, RS: old|op, RC: old&~op, with op = imm_sel ? {27'b0,zimm} : rs1_data.
REQ-014 SHALL make the write visible at the next rising clk edge (1-cycle latency).
REQ-015 SHALL suppress the write for RS/RC when rs1_zero=1, so the operation has no side effects.
REQ-016 SHALL assert illegal combinationally, with no state change, for csr_en with:
  - an unimplemented address (rd_data=0), or
  - a write to a read-only CSR (addr[11:10]=11 or misa).
REQ-017 SHALL increment the 64-bit mcycle every cycle and the 64-bit minstret when instr_retired=1.
REQ-018 SHALL let a software write to any counter half take priority over the increment in that cycle; the other half keeps counting, with carry.
REQ-019 SHALL wrap the 64-bit counters from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-020 SHALL OR fflags_set into fflags each cycle; a same-cycle software write to fflags or fcsr wins.
REQ-021 SHALL, on trap_en (highest priority, overriding any CSR write that cycle):
  - set mepc=trap_pc, mcause=trap_cause, mtval=trap_val
  - set MPIE=MIE, then MIE=0
REQ-022 SHALL, on mret (when trap_en=0), set MIE=MPIE and MPIE=1.
REQ-023 SHALL act on trap_en only when trap_en and mret are asserted together.

Reset
REQ-024 SHALL asynchronously clear on rst_n=0:
  - all writable CSRs, counters, and fflags/frm to 0
  - MIE and MPIE to 0
  - outputs to 0, except mstatus reads MPP=11
REQ-025 SHALL begin counting mcycle on the first rising edge after rst_n deasserts; reset mid-operation discards any pending write.

Structure
REQ-026 SHALL take CSR address constants, csr_op encodings, and the MISA value from a shared package csr_pkg.
REQ-027 SHALL be a single module; the 64-bit counter may be one sub-module, csr_counter64, instantiated twice.

Verification
REQ-028 SHALL cover: CSRRW 0x340 with rs1_data=0xDEADBEEF -> rd_data=0 that cycle; a read of 0x340 next cycle returns 0xDEADBEEF.
REQ-029 SHALL cover: CSRRS 0x340 with 0x0000_00F0, then CSRRC with 0xDE00_0000 -> reads 0xDEADBEFF, then 0x00ADBEFF.
REQ-030 SHALL cover: reset released, 10 clocks idle, read 0xB00 -> 10 (±1 by sampling edge); write 0xB00=0xFFFFFFFF, next cycle 0xB80 increments by 1.
REQ-031 SHALL cover: fflags_set=5'b00001 then 5'b10000 -> fcsr reads 0x11; CSRRWI fcsr zimm=0 -> reads 0.
REQ-032 SHALL cover: MIE=1 via CSRRSI 0x300 zimm=8, then trap_en with trap_pc=0x100 and cause=2:
  - next cycle mepc_out=0x100, mcause=2, mstatus_mie=0, MPIE=1
  - after mret, mstatus_mie=1
REQ-033 SHALL cover: CSRRW to 0xC00 or 0x7FF -> illegal=1 with no state change; CSRRS 0xC00 with rs1_zero=1 -> illegal=0.
